// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Seven-segment pattern decoder and stability monitor. Scans the eight
// active-low segment buses one digit per enabled cycle, decodes each pattern
// into a class {err, blank, dp, nibble}, and commits a digit's class only after
// it has been observed STABLE_SCANS consecutive visits in a row.
//
// Parameters
//   STABLE_SCANS : consecutive identical visits required before commit (1..15)
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   i_en         : scan enable; all state holds while low
//   i_seg0..7    : active-low segment buses, bit7..bit1 = a..g, bit0 = dp
//   o_data       : committed nibbles, digit k at [4k+3:4k] (0 if blank/invalid)
//   o_blank      : bit k = digit k committed as blank
//   o_dp         : bit k = digit k committed with dp lit
//   o_err        : bit k = digit k committed as an invalid pattern
//   o_upd        : one-cycle pulse, a digit's committed class changed
//   o_scan_done  : one-cycle pulse, scan index wrapped from 7 to 0
// -----------------------------------------------------------------------------
module seg_decode #(
    parameter int STABLE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [7:0]  i_seg0,
    input  logic [7:0]  i_seg1,
    input  logic [7:0]  i_seg2,
    input  logic [7:0]  i_seg3,
    input  logic [7:0]  i_seg4,
    input  logic [7:0]  i_seg5,
    input  logic [7:0]  i_seg6,
    input  logic [7:0]  i_seg7,
    output logic [31:0] o_data,
    output logic [7:0]  o_blank,
    output logic [7:0]  o_dp,
    output logic [7:0]  o_err,
    output logic        o_upd,
    output logic        o_scan_done
);

    localparam logic [3:0] STABLE_CNT  = 4'(STABLE_SCANS);
    // Class layout {err, blank, dp, nibble[3:0]}; blank with dp off.
    localparam logic [6:0] BLANK_CLASS = 7'b010_0000;

    // Turn one active-low bus into its class. Nibble stays 0 unless the
    // segment field is a recognised hex glyph.
    function automatic logic [6:0] classify(input logic [7:0] seg_n);
        logic [7:0] pat;
        logic [3:0] nib;
        logic       err;
        logic       blank;
        pat   = ~seg_n;
        nib   = 4'h0;
        err   = 1'b0;
        blank = 1'b0;
        case (pat[7:1])
            7'h7E:   nib = 4'h0;
            7'h30:   nib = 4'h1;
            7'h6D:   nib = 4'h2;
            7'h79:   nib = 4'h3;
            7'h33:   nib = 4'h4;
            7'h5B:   nib = 4'h5;
            7'h5F:   nib = 4'h6;
            7'h70:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h73:   nib = 4'h9;
            7'h77:   nib = 4'hA;
            7'h1F:   nib = 4'hB;
            7'h4E:   nib = 4'hC;
            7'h3D:   nib = 4'hD;
            7'h4F:   nib = 4'hE;
            7'h47:   nib = 4'hF;
            7'h00:   blank = 1'b1;
            default: err = 1'b1;
        endcase
        return {err, blank, pat[0], nib};
    endfunction

    logic [2:0] r_idx;
    logic [6:0] r_cand [8];
    logic [3:0] r_cnt  [8];
    logic [31:0] r_data;
    logic [7:0]  r_blank;
    logic [7:0]  r_dp;
    logic [7:0]  r_err;
    logic        r_upd;
    logic        r_scan_done;

    logic [7:0] w_seg;
    logic [6:0] w_class;
    logic [6:0] w_comm;
    logic [3:0] w_cnt_cur;
    logic [3:0] w_cnt_nxt;
    logic       w_commit;

    // Pick the bus belonging to the digit in the current scan slot.
    always_comb begin
        w_seg = 8'hFF;
        case (r_idx)
            3'd0:    w_seg = i_seg0;
            3'd1:    w_seg = i_seg1;
            3'd2:    w_seg = i_seg2;
            3'd3:    w_seg = i_seg3;
            3'd4:    w_seg = i_seg4;
            3'd5:    w_seg = i_seg5;
            3'd6:    w_seg = i_seg6;
            3'd7:    w_seg = i_seg7;
            default: w_seg = 8'hFF;
        endcase
    end

    // Classify the sample and rebuild the currently committed class of this digit.
    always_comb begin
        w_class   = classify(w_seg);
        w_comm    = {r_err[r_idx], r_blank[r_idx], r_dp[r_idx],
                     r_data[{r_idx, 2'b00} +: 4]};
        w_cnt_cur = r_cnt[r_idx];
    end

    // Stability count: a repeat extends the run (saturating), a change restarts
    // it at 1 with the new class as candidate. Commit fires on the visit where
    // the run reaches the threshold with a class not already committed.
    always_comb begin
        w_cnt_nxt = 4'd1;
        if (w_class == r_cand[r_idx]) begin
            if (w_cnt_cur >= STABLE_CNT) begin
                w_cnt_nxt = STABLE_CNT;
            end else begin
                w_cnt_nxt = w_cnt_cur + 4'd1;
            end
        end else begin
            w_cnt_nxt = 4'd1;
        end
        w_commit = (w_cnt_nxt == STABLE_CNT) && (w_class != w_comm);
    end

    // Scan index and per-digit candidate/counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                r_cand[k] <= BLANK_CLASS;
                r_cnt[k]  <= 4'd0;
            end
        end else if (i_en) begin
            // After this visit the candidate equals the sampled class either way.
            r_cand[r_idx] <= w_class;
            r_cnt[r_idx]  <= w_cnt_nxt;
            r_idx         <= r_idx + 3'd1;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Committed fields and the two status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data      <= 32'h0000_0000;
            r_blank     <= 8'hFF;
            r_dp        <= 8'h00;
            r_err       <= 8'h00;
            r_upd       <= 1'b0;
            r_scan_done <= 1'b0;
        end else if (i_en) begin
            r_upd       <= w_commit;
            r_scan_done <= (r_idx == 3'd7);
            if (w_commit) begin
                r_data[{r_idx, 2'b00} +: 4] <= w_class[3:0];
                r_dp[r_idx]                 <= w_class[4];
                r_blank[r_idx]              <= w_class[5];
                r_err[r_idx]                <= w_class[6];
            end else begin
                r_data <= r_data;
            end
        end else begin
            r_upd       <= 1'b0;
            r_scan_done <= 1'b0;
        end
    end

    assign o_data      = r_data;
    assign o_blank     = r_blank;
    assign o_dp        = r_dp;
    assign o_err       = r_err;
    assign o_upd       = r_upd;
    assign o_scan_done = r_scan_done;

endmodule

// File: tb/tb_seg_decode.sv
// -----------------------------------------------------------------------------
// tb_seg_decode
// Self-checking bench for seg_decode. A per-digit model of candidate, run
// length and committed class (kept as plain integers) predicts every output;
// a negedge process compares DUT against it each cycle, and directed phases
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seg_decode;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [7:0]  seg [8];
    logic [31:0] o_data;
    logic [7:0]  o_blank;
    logic [7:0]  o_dp;
    logic [7:0]  o_err;
    logic        o_upd;
    logic        o_scan_done;

    seg_decode #(.STABLE_SCANS(S)) dut (
        .clk(clk), .rst(rst), .i_en(en),
        .i_seg0(seg[0]), .i_seg1(seg[1]), .i_seg2(seg[2]), .i_seg3(seg[3]),
        .i_seg4(seg[4]), .i_seg5(seg[5]), .i_seg6(seg[6]), .i_seg7(seg[7]),
        .o_data(o_data), .o_blank(o_blank), .o_dp(o_dp), .o_err(o_err),
        .o_upd(o_upd), .o_scan_done(o_scan_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    int s_upd    = 0;
    int s_done   = 0;

    // Model: class value = err*64 + blank*32 + dp*16 + nibble
    int m_idx;
    int m_cand [8];
    int m_cnt  [8];
    int m_com  [8];
    bit m_upd;
    bit m_done;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    function automatic int classify(input logic [7:0] sg);
        logic [7:0] p;
        logic [6:0] s;
        int c;
        p = ~sg;
        s = p[7:1];
        c = p[0] ? 16 : 0;
        if (s == 7'h00) return c + 32;
        for (int n = 0; n < 16; n++) begin
            if (seg_tab[n] == s) return c + n;
        end
        return c + 64;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_upd  = 1'b0;
        m_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_cand[k] = 32;
            m_cnt[k]  = 0;
            m_com[k]  = 32;
        end
    endtask

    task automatic model_step();
        int k;
        int c;
        if (!rst) begin
            model_reset();
            return;
        end
        m_upd  = 1'b0;
        m_done = 1'b0;
        if (en) begin
            k = m_idx;
            c = classify(seg[k]);
            if (c == m_cand[k]) m_cnt[k] = (m_cnt[k] < S) ? m_cnt[k] + 1 : S;
            else begin
                m_cand[k] = c;
                m_cnt[k]  = 1;
            end
            if (m_cnt[k] == S && m_cand[k] != m_com[k]) begin
                m_com[k] = m_cand[k];
                m_upd    = 1'b1;
            end
            m_done = (m_idx == 7);
            m_idx  = (m_idx + 1) % 8;
        end
    endtask

    function automatic logic [31:0] exp_data();
        logic [31:0] d;
        d = 32'h0;
        for (int k = 0; k < 8; k++) d = d | (32'(m_com[k] % 16) << (4 * k));
        return d;
    endfunction

    function automatic logic [7:0] exp_bits(input int div);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) b[k] = ((m_com[k] / div) % 2) == 1;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_data",  o_data,                exp_data());
            check("cyc_blank", 32'(o_blank),          32'(exp_bits(32)));
            check("cyc_dp",    32'(o_dp),             32'(exp_bits(16)));
            check("cyc_err",   32'(o_err),            32'(exp_bits(64)));
            check("cyc_upd",   32'(o_upd),            32'(m_upd));
            check("cyc_done",  32'(o_scan_done),      32'(m_done));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (o_upd) s_upd++;
        if (o_scan_done) s_done++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idx(input int target);
        for (int i = 0; i < 8 && m_idx != target; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},  o_data,              32'h0);
        check({tag, "_blank"}, 32'(o_blank),        32'hFF);
        check({tag, "_dp"},    32'(o_dp),           32'h0);
        check({tag, "_err"},   32'(o_err),          32'h0);
        check({tag, "_upd"},   32'(o_upd),          32'h0);
        check({tag, "_done"},  32'(o_scan_done),    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int k = 0; k < 8; k++) seg[k] = 8'hFF;
        rst = 1'b0;
        en  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        checking = 1'b1;
        rst = 1'b1;

        // All blank: nothing commits, scan_done every 8th cycle
        s_upd = 0; s_done = 0;
        run(64);
        check("idle_done_count", 32'(s_done), 32'd8);
        check("idle_upd_count",  32'(s_upd),  32'd0);
        check("idle_blank",      32'(o_blank), 32'hFF);

        // Digit 1 = 9, digit 2 = B
        seg[1] = ~8'hE6;
        seg[2] = ~8'h3E;
        s_upd = 0;
        run(40);
        check("b9_data",  32'(o_data[11:4]), 32'hB9);
        check("b9_blank", 32'(o_blank),      32'hF9);
        check("b9_dp",    32'(o_dp),         32'h00);
        check("b9_upd",   32'(s_upd),        32'd2);

        // Digit 0 = 0 with dp, then blank with dp
        seg[0] = ~8'hFD;
        run(40);
        check("d0_nib",   32'(o_data[3:0]), 32'h0);
        check("d0_dp",    32'(o_dp[0]),     32'h1);
        check("d0_blank", 32'(o_blank[0]),  32'h0);
        seg[0] = ~8'h01;
        run(40);
        check("d0b_blank", 32'(o_blank[0]), 32'h1);
        check("d0b_dp",    32'(o_dp[0]),    32'h1);

        // Digit 3 invalid, then 8
        seg[3] = ~8'h02;
        run(40);
        check("d3_err",  32'(o_err[3]),       32'h1);
        check("d3_nib",  32'(o_data[15:12]),  32'h0);
        seg[3] = ~8'hFE;
        run(40);
        check("d3r_err", 32'(o_err[3]),       32'h0);
        check("d3r_nib", 32'(o_data[15:12]),  32'h8);

        // Digit 5 stable at 3, then one-visit glitch to 7
        seg[5] = ~8'hF2;
        run(40);
        check("d5_nib", 32'(o_data[23:20]), 32'h3);
        wait_idx(5);
        seg[5] = ~8'hE0;
        s_upd = 0;
        step();
        seg[5] = ~8'hF2;
        run(40);
        check("glitch_upd", 32'(s_upd),          32'd0);
        check("glitch_nib", 32'(o_data[23:20]),  32'h3);

        // Continuous latency, change lands just before digit 6's slot
        wait_idx(6);
        seg[6] = ~8'h60;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            lat++;
            if (o_upd) break;
        end
        check("lat_continuous", 32'(lat), 32'd25);
        check("d6_nib", 32'(o_data[27:24]), 32'h1);

        // Same change on digit 7 with enable toggling every other cycle
        wait_idx(7);
        seg[7] = ~8'h60;
        lat = 0;
        for (int i = 1; i <= 150; i++) begin
            en = (i % 2) == 1;
            step();
            lat++;
            if (o_upd) break;
        end
        en = 1'b1;
        check("lat_toggled", 32'(lat), 32'd49);
        check("d7_nib", 32'(o_data[31:28]), 32'h1);

        // Asynchronous reset mid-scan
        run(3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_values("async");
        run(2);
        rst = 1'b1;
        s_done = 0;
        run(8);
        check("resume_done", 32'(s_done), 32'd1);
        run(40);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_decode.md
# seg_decode

Seven-segment pattern decoder and stability monitor: the receive-side counterpart of the hex-to-segment display driver. It scans the eight active-low segment buses one digit per enabled cycle, decodes each pattern back to a hex nibble, blank, or invalid, and commits a digit only after its pattern has held for `STABLE_SCANS` consecutive visits. It sits beside the display driver in the NPC simulation top, where it lets testbenches and self-check logic read back what the board would show.

## Interface
- `STABLE_SCANS`, default 4: consecutive identical samples of one digit required before commit; legal range 1..15.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  scan enable; when low, all state holds.
- `i_seg0`..`i_seg7`  in  8 each  active-low segment buses; bit7..bit1 = a..g, bit0 = dp; `i_seg0` is digit 0.
- `o_data`  out  32  committed nibbles; digit k at [4k+3:4k]; 0 for blank or invalid digits.
- `o_blank`  out  8  bit k = digit k committed as blank.
- `o_dp`  out  8  bit k = committed dp lit for digit k.
- `o_err`  out  8  bit k = digit k committed as an invalid pattern.
- `o_upd`  out  1  one-cycle pulse; some digit's committed class changed this edge.
- `o_scan_done`  out  1  one-cycle pulse on the edge where the scan index wraps from 7 to 0.

## Operation
- Active-high pattern p = ~`i_seg[idx]`; s = p[7:1]; dp = p[0].
- Decode table, s to nibble: 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F.
- s = 00 means blank. Any other s not in the table means error. dp is independent of s and is always reported.
- Class per sample is the 7-bit value {err, blank, dp, nibble}. Nibble is forced to 0 when err or blank is set.
- Each digit keeps a candidate class `cand[k]` and a 4-bit counter `cnt[k]`.
- On each enabled cycle, digit `idx` is sampled:
  - If the class equals `cand[idx]`, `cnt` increments and saturates at `STABLE_SCANS`.
  - Otherwise, `cand[idx]` takes the new class and `cnt` is set to 1.
- Commit happens when the updated `cnt` equals `STABLE_SCANS` and `cand` differs from the committed class of that digit.
  - The committed fields for that digit update.
  - `o_upd` is high that cycle.
  - Holding a stable class produces no further commits or pulses.
- Only digit `idx` can commit in a given cycle, so at most one digit changes per edge.
- `idx` is a 3-bit counter that advances by 1 per enabled cycle and wraps 7→0.
- With `STABLE_SCANS` = 1, every class change commits on its first sample.

## Timing
- Reset values: `idx`=0; `cand`=blank class and `cnt`=0 for all digits; `o_data`=0; `o_blank`=8'hFF; `o_dp`=0; `o_err`=0; `o_upd`=0; `o_scan_done`=0.
- All outputs are registered. `o_upd` and `o_scan_done` are single-cycle pulses, valid in the cycle after the enabling edge.
- Latency from a stable pattern change on digit k to commit:
  - Best case (change lands just before digit k's slot): 8·(`STABLE_SCANS`−1)+1 enabled cycles.
  - Worst case (change lands just after digit k's slot): 8·`STABLE_SCANS` enabled cycles.
- When `i_en` is low:
  - `idx`, `cand`, `cnt` and all committed outputs hold.
  - `o_upd` and `o_scan_done` are 0.
  - Stalls do not reset the stability counters.
- Glitch handling: a pattern that differs on one visit restarts that digit's count at 1 with the glitch as candidate. The committed value holds until some class survives `STABLE_SCANS` visits.
- Asserting `rst` mid-scan immediately restores every reset value, including pulses. Scanning resumes at digit 0 on the first enabled edge after release.
- Inputs are sampled only during their digit's slot. Changes between visits are invisible by design.

## Test plan
- Reset, all `i_seg*` = 8'hFF, `i_en`=1 for 64 cycles:
  - `o_blank` stays 8'hFF, `o_data`=0, `o_err`=0.
  - `o_upd` never pulses.
  - `o_scan_done` pulses every 8th cycle.
- `i_seg1`=~8'hE6 (9) and `i_seg2`=~8'h3E (B), `STABLE_SCANS`=4:
  - `o_data`[11:4] becomes 8'hB9 and `o_blank`=8'hF9 after the fourth visit.
  - `o_upd` pulses exactly twice.
  - `o_dp`=0.
- `i_seg0`=~8'hFD:
  - Commits nibble 0 with `o_dp`[0]=1 and `o_blank`[0]=0.
  - Then `i_seg0`=~8'h01 commits blank with `o_dp`[0]=1.
- `i_seg3`=~8'h02 (g only, invalid):
  - `o_err`[3]=1 and `o_data`[15:12]=0.
  - Restoring ~8'hFE clears `o_err`[3] and commits 8 after 4 visits.
- Digit 5 stable at 3 (~8'hF2), then pattern 7 (~8'hE0) for a single visit, then back to 3:
  - No commit and no `o_upd`.
  - `o_data`[23:20] stays 3 throughout.
- Toggle `i_en` every other cycle during a commit, then pulse `rst` low mid-scan:
  - Commit arrives after twice the cycles of the continuous case.
  - Reset returns all outputs to their reset values asynchronously.
